// File: rtl/lif_pkg.sv
// Shared definitions for the binary-weight LIF spiking layer.
//   sum_w(in_log2) : signed width of the synaptic sum / threshold
//   mem_w(in_log2) : signed width of the membrane potential
//   QFRAC          : fraction bits of the unsigned Q2.2 batch-norm factor
//   sat()          : clamp a signed value into a given two's complement width
package lif_pkg;

  localparam int QFRAC = 2;

  function automatic int sum_w(input int in_log2);
    return in_log2 + 2;
  endfunction

  function automatic int mem_w(input int in_log2);
    return in_log2 + 6;
  endfunction

  function automatic logic signed [31:0] sat(input logic signed [31:0] v,
                                             input int                 width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky-integrate-and-fire neuron with +/-1 binary weights.
// Ports:
//   clk, rst_n (active-high sync reset), ce (clock enable)
//   x          : NI input spikes
//   w_col      : NI weights for this neuron (1 = +1, 0 = -1)
//   conn_col   : NI synapse enables for this neuron
//   factor     : unsigned Q2.2 batch-norm scale
//   addend     : signed batch-norm offset (SW bits)
//   beta_shift : leak shift (0 disables the leak)
//   minus_teta : negated firing threshold (SW bits, signed)
//   spike      : registered spike output
module lif_neuron
  import lif_pkg::*;
#(
  parameter  int IN_LOG2 = 5,
  localparam int NI      = 2 ** IN_LOG2,
  localparam int SW      = sum_w(IN_LOG2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [NI-1:0]        x,
  input  logic [NI-1:0]        w_col,
  input  logic [NI-1:0]        conn_col,
  input  logic [3:0]           factor,
  input  logic signed [SW-1:0] addend,
  input  logic [2:0]           beta_shift,
  input  logic signed [SW-1:0] minus_teta,
  output logic                 spike
);

  localparam int MW = mem_w(IN_LOG2);
  // Headroom for sum*factor before the Q2.2 shift and the membrane update.
  localparam int BW = MW + 4;

  logic signed [SW-1:0] sum;
  logic signed [BW-1:0] sum_x;
  logic signed [BW-1:0] fac_x;
  logic signed [BW-1:0] prod;
  logic signed [BW-1:0] bn;
  logic signed [BW-1:0] u_x;
  logic signed [BW-1:0] leak;
  logic signed [BW-1:0] fire_acc;
  logic signed [MW-1:0] n_mem;
  logic signed [MW-1:0] u_q;
  logic signed [MW-1:0] u_d;
  logic                 spike_q;
  logic                 spike_d;

  function automatic logic signed [MW-1:0] sat_mw(input logic signed [BW-1:0] v);
    return MW'(sat(32'(v), MW));
  endfunction

  always_comb begin
    sum = '0;
    for (int i = 0; i < NI; i++) begin
      if (x[i] & conn_col[i]) begin
        sum = w_col[i] ? sum + SW'(1) : sum - SW'(1);
      end
    end

    sum_x = BW'(sum);
    fac_x = signed'(BW'(factor));
    prod  = sum_x * fac_x;
    // Arithmetic shift drops the Q2.2 fraction, rounding toward -inf.
    bn    = (prod >>> QFRAC) + BW'(addend);

    u_x = BW'(u_q);
    // A zero shift means "no leak", not "leak everything".
    if (beta_shift == 3'd0) begin
      leak = '0;
    end else begin
      leak = u_x >>> beta_shift;
    end

    n_mem    = sat_mw(u_x - leak + bn);
    fire_acc = BW'(n_mem) + BW'(minus_teta);
    spike_d  = ~fire_acc[BW-1];
    // Reset-by-subtraction keeps the overshoot above threshold.
    u_d      = spike_d ? sat_mw(fire_acc) : n_mem;
  end

  // Stage p0 -> registered membrane and spike
  always_ff @(posedge clk) begin
    if (rst_n) begin
      u_q     <= '0;
      spike_q <= 1'b0;
    end else if (ce) begin
      u_q     <= u_d;
      spike_q <= spike_d;
    end
  end

  assign spike = spike_q;

endmodule

// File: rtl/lif_layer.sv
// A layer of NEURONS independent binary-weight LIF neurons sharing NI inputs.
// Ports:
//   clk, rst_n (active-high sync reset), ce (clock enable)
//   x                  : NI input spikes
//   w                  : NI*NO weights, bit i*NO+j links input i to neuron j
//   connection_enabled : NI*NO synapse enables, same layout as w
//   beta_shift         : layer leak shift
//   minus_teta         : negated layer threshold (SW bits)
//   BN_factor          : 4 bits per neuron, unsigned Q2.2
//   BN_addend          : SW bits per neuron, signed
//   spike_out          : NO registered spikes
module lif_layer
  import lif_pkg::*;
#(
  parameter  int IN_LOG2 = 5,
  parameter  int NEURONS = 256,
  localparam int NI      = 2 ** IN_LOG2,
  localparam int NO      = NEURONS,
  localparam int SW      = sum_w(IN_LOG2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic [NI-1:0]      x,
  input  logic [NI*NO-1:0]   w,
  input  logic [NI*NO-1:0]   connection_enabled,
  input  logic [2:0]         beta_shift,
  input  logic [SW-1:0]      minus_teta,
  input  logic [4*NO-1:0]    BN_factor,
  input  logic [SW*NO-1:0]   BN_addend,
  output logic [NO-1:0]      spike_out
);

  for (genvar j = 0; j < NO; j++) begin : g_neuron
    logic [NI-1:0] w_col;
    logic [NI-1:0] c_col;

    // Gather neuron j's column out of the input-major flat buses.
    for (genvar i = 0; i < NI; i++) begin : g_tap
      assign w_col[i] = w[i*NO + j];
      assign c_col[i] = connection_enabled[i*NO + j];
    end

    lif_neuron #(.IN_LOG2(IN_LOG2)) u_neuron (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (ce),
      .x          (x),
      .w_col      (w_col),
      .conn_col   (c_col),
      .factor     (BN_factor[4*j +: 4]),
      .addend     (BN_addend[SW*j +: SW]),
      .beta_shift (beta_shift),
      .minus_teta (minus_teta),
      .spike      (spike_out[j])
    );
  end

endmodule

// File: tb/tb_lif_layer.sv
module tb_lif_layer;

  localparam int IN_LOG2 = 2;
  localparam int NO      = 2;
  localparam int NI      = 4;
  localparam int SW      = 4;
  localparam int MW      = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ce;
  logic [NI-1:0]     x;
  logic [NI*NO-1:0]  w;
  logic [NI*NO-1:0]  conn;
  logic [2:0]        beta_shift;
  logic [SW-1:0]     minus_teta;
  logic [4*NO-1:0]   bn_factor;
  logic [SW*NO-1:0]  bn_addend;
  logic [NO-1:0]     spike_out;

  int n_checks = 0;
  int n_fail   = 0;

  int          u_m [NO];
  logic [NO-1:0] spk_m;

  always #5 clk = ~clk;

  lif_layer #(.IN_LOG2(IN_LOG2), .NEURONS(NO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ce                 (ce),
    .x                  (x),
    .w                  (w),
    .connection_enabled (conn),
    .beta_shift         (beta_shift),
    .minus_teta         (minus_teta),
    .BN_factor          (bn_factor),
    .BN_addend          (bn_addend),
    .spike_out          (spike_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int clamp(input int v);
    int hi = (1 << (MW - 1)) - 1;
    int lo = -(1 << (MW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: one clock edge of the layer, from the arithmetic rules.
  task automatic model_edge();
    if (rst_n) begin
      for (int j = 0; j < NO; j++) u_m[j] = 0;
      spk_m = '0;
    end else if (ce) begin
      for (int j = 0; j < NO; j++) begin
        int s = 0;
        int f, a, mt, b, l, n;
        for (int i = 0; i < NI; i++)
          if (x[i] && conn[i*NO + j]) s += w[i*NO + j] ? 1 : -1;
        f  = int'(bn_factor[4*j +: 4]);
        a  = int'($signed(bn_addend[SW*j +: SW]));
        mt = int'($signed(minus_teta));
        b  = fdiv(s * f, 4) + a;
        l  = (beta_shift == 0) ? 0 : fdiv(u_m[j], 1 << beta_shift);
        n  = clamp(u_m[j] - l + b);
        if (n + mt >= 0) begin
          spk_m[j] = 1'b1;
          u_m[j]   = clamp(n + mt);
        end else begin
          spk_m[j] = 1'b0;
          u_m[j]   = n;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_eq(tag, 32'(spike_out), 32'(spk_m));
  endtask

  task automatic set_fire_case();
    x          = 4'b1111;
    w          = '1;
    conn       = '1;
    bn_factor  = {4'd4, 4'd4};
    bn_addend  = '0;
    beta_shift = 3'd0;
    minus_teta = 4'b1011;  // -5
    ce         = 1'b1;
  endtask

  initial begin
    for (int j = 0; j < NO; j++) u_m[j] = 0;
    spk_m = '0;

    // Reset with arbitrary inputs
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      x = 4'($urandom); w = 8'($urandom); conn = 8'($urandom);
      beta_shift = 3'($urandom); minus_teta = 4'($urandom);
      bn_factor = 8'($urandom); bn_addend = 8'($urandom); ce = 1'($urandom);
      step("reset");
      check_eq("reset_zero", 32'(spike_out), 32'h0);
    end
    rst_n = 1'b0;

    // Integrate and fire, with a 5-cycle ce freeze in the middle
    set_fire_case();
    for (int k = 0; k < 2; k++) step("fire_a");
    check_eq("fire_first_spike", 32'(spike_out), 32'h3);
    ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      x = 4'($urandom);
      step("ce_hold");
    end
    set_fire_case();
    for (int k = 0; k < 4; k++) step("fire_b");

    // Reset mid-run after spikes
    rst_n = 1'b1;
    step("mid_reset");
    check_eq("mid_reset_zero", 32'(spike_out), 32'h0);
    rst_n = 1'b0;

    // Connection mask: neuron 1 fully disconnected
    set_fire_case();
    conn = 8'b0101_0101;
    for (int k = 0; k < 8; k++) step("conn_mask");
    check_eq("conn_mask_n1", 32'(spike_out[1]), 32'h0);

    // Negative saturation, then recovery time exposes the clamp level
    rst_n = 1'b1; step("sat_reset"); rst_n = 1'b0;
    set_fire_case();
    w = '0;
    for (int k = 0; k < 40; k++) step("neg_sat");
    w = '1;
    for (int k = 0; k < 40; k++) step("sat_recover");

    // Leak steady state: u settles at 6 below threshold 7
    rst_n = 1'b1; step("leak_reset"); rst_n = 1'b0;
    x = '0; bn_factor = '0; bn_addend = {4'd3, 4'd3};
    beta_shift = 3'd1; minus_teta = 4'b1001;  // -7
    for (int k = 0; k < 10; k++) step("leak");
    check_eq("leak_no_spike", 32'(spike_out), 32'h0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      rst_n = ($urandom_range(0, 40) == 0);
      ce    = ($urandom_range(0, 3) != 0);
      x = 4'($urandom); w = 8'($urandom); conn = 8'($urandom);
      beta_shift = 3'($urandom); minus_teta = 4'($urandom);
      bn_factor = 8'($urandom); bn_addend = 8'($urandom);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
